multicycle_control: RTL

Main control FSM for the multi-cycle RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath strobes and mux selects, and produces the 2-bit `alu_op` code consumed by the ALU-control decoder. That decoder combines `alu_op` with funct7/funct3 to select the ALU operation. This block sits directly upstream of the ALU-control decoder.

---
 rtl/multicycle_control.sv | 137 +++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multi-cycle RV32I datapath: fetch, decode, execute,
// memory and writeback, plus the 2-bit alu_op handed to the ALU-control decoder.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       br_cond,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        ILLEGAL = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t cur;

    assign state = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: cur <= MEMADR;
                        OP_RTYPE:          cur <= EXECR;
                        OP_ITYPE:          cur <= EXECI;
                        OP_BRANCH:         cur <= BRANCH;
                        default:           cur <= ILLEGAL;
                    endcase
                end
                MEMADR:  cur <= (opcode == OP_LOAD) ? MEMRD : MEMWR;
                MEMRD:   if (mem_ready) cur <= MEMWB;
                MEMWB:   cur <= FETCH;
                MEMWR:   if (mem_ready) cur <= FETCH;
                EXECR:   cur <= ALUWB;
                EXECI:   cur <= ALUWB;
                ALUWB:   cur <= FETCH;
                BRANCH:  cur <= FETCH;
                ILLEGAL: cur <= ILLEGAL;
                default: cur <= ILLEGAL;
            endcase
        end
    end

    // Moore decode of the state register; only the memory/branch strobes look at inputs.
    always_comb begin
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (cur)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMRD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
            end
            ALUWB:   reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = br_cond;
            end
            ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
